// File: rtl/ascon_dom_pkg.sv
// Shared constants, state codes and round-constant helper for the Ascon DOM round controller.
// Optional feature macro used by the controller: ASCON_CTRL_RND_HANDSHAKE_EN.
package ascon_dom_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned RC_W    = 4;
  localparam int unsigned STAGE_W = 2;
  localparam int unsigned ROUND_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [1:0] RCM_CLEAR = 2'b00;
  localparam logic [1:0] RCM_INC0  = 2'b01;
  localparam logic [1:0] RCM_INC6  = 2'b10;
  localparam logic [1:0] RCM_LOAD  = 2'b11;

  localparam int unsigned PA_ROUNDS = 12;
  localparam int unsigned PB_ROUNDS = 6;

  localparam logic [RC_W-1:0] PA_RC_START = 4'h0;
  localparam logic [RC_W-1:0] PB_RC_START = 4'h6;
  localparam logic [RC_W-1:0] RC_LAST     = 4'hB;

  // Round-constant index step, wrapping to the start index of the selected permutation.
  function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc, input logic sel);
    logic [RC_W-1:0] nxt;
    if (rc == RC_LAST) nxt = sel ? PB_RC_START : PA_RC_START;
    else               nxt = rc + RC_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/ascon_round_ctrl_dom_if.sv
// Control/status bundle between the permutation datapath parent and the round controller.
// rnd_valid_i only exists when ASCON_CTRL_RND_HANDSHAKE_EN is defined.
interface ascon_round_ctrl_dom_if;
  logic       start_i;
  logic       perm_sel_i;
`ifdef ASCON_CTRL_RND_HANDSHAKE_EN
  logic       rnd_valid_i;
`endif
  logic [1:0] rcmode_o;
  logic [3:0] constti_o;
  logic       round_upd_o;
  logic [1:0] stage_o;
  logic       rnd_req_o;
  logic       busy_o;
  logic       done_o;

`ifdef ASCON_CTRL_RND_HANDSHAKE_EN
  modport master (output start_i, perm_sel_i, rnd_valid_i,
                  input  rcmode_o, constti_o, round_upd_o, stage_o, rnd_req_o, busy_o, done_o);
  modport slave  (input  start_i, perm_sel_i, rnd_valid_i,
                  output rcmode_o, constti_o, round_upd_o, stage_o, rnd_req_o, busy_o, done_o);
`else
  modport master (output start_i, perm_sel_i,
                  input  rcmode_o, constti_o, round_upd_o, stage_o, rnd_req_o, busy_o, done_o);
  modport slave  (input  start_i, perm_sel_i,
                  output rcmode_o, constti_o, round_upd_o, stage_o, rnd_req_o, busy_o, done_o);
`endif
endinterface

// File: rtl/ascon_round_ctrl_dom.sv
// Sequencer for a DOM-masked Ascon permutation: drives the external round-constant generator,
// share-register update strobes and randomness requests. Stall support: ASCON_CTRL_RND_HANDSHAKE_EN.
module ascon_round_ctrl_dom #(
  parameter int unsigned ROUND_LAT = 2
) (
  input logic                  clk,
  input logic                  nRST,
  ascon_round_ctrl_dom_if.slave bus
);
  import ascon_dom_pkg::*;

  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(ROUND_LAT - 1);

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic [RC_W-1:0]      rc_q, rc_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [ROUND_W-1:0]   round_last;
  logic                 advance;

  logic [1:0]           rcmode;
  logic [RC_W-1:0]      constti;
  logic                 round_upd, rnd_req, busy, done;

`ifdef ASCON_CTRL_RND_HANDSHAKE_EN
  assign advance = bus.rnd_valid_i;
`else
  assign advance = 1'b1;
`endif

  assign round_last = sel_q ? ROUND_W'(PB_ROUNDS - 1) : ROUND_W'(PA_ROUNDS - 1);

  // State, selection, constant index and counters.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      rc_q    <= '0;
      round_q <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rc_q    <= rc_d;
      round_q <= round_d;
      stage_q <= stage_d;
    end
  end

  // Next-state and decoded outputs; IDLE decodes to all-zero so reset clears outputs at once.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rc_d      = rc_q;
    round_d   = round_q;
    stage_d   = stage_q;
    rcmode    = RCM_CLEAR;
    constti   = '0;
    round_upd = 1'b0;
    rnd_req   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.start_i) begin
          sel_d   = bus.perm_sel_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rcmode  = RCM_LOAD;
        constti = sel_q ? PB_RC_START : PA_RC_START;
        rc_d    = constti;
        round_d = '0;
        stage_d = '0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        rcmode  = RCM_LOAD;
        constti = rc_q;
        if (advance) begin
          rnd_req = 1'b1;
          if (stage_q == STAGE_LAST) begin
            round_upd = 1'b1;
            rcmode    = sel_q ? RCM_INC6 : RCM_INC0;
            rc_d      = rc_next(rc_q, sel_q);
            stage_d   = '0;
            round_d   = round_q + ROUND_W'(1);
            if (round_q == round_last) state_d = ST_DONE;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rcmode_o    = rcmode;
  assign bus.constti_o   = constti;
  assign bus.round_upd_o = round_upd;
  assign bus.stage_o     = stage_q;
  assign bus.rnd_req_o   = rnd_req;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;

endmodule

// File: doc/ascon_round_ctrl_dom.md
ASCON_ROUND_CTRL_DOM -- requirements
Module: ascon_round_ctrl_dom

Interface
REQ-001 Parameter ROUND_LAT, default 2, cycles per DOM round (legal 1..4; S-box share-register stages plus linear layer).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request a permutation; sampled only in IDLE.
REQ-005 perm_sel_i  input  1  0 = p^a (12 rounds, constant index 0..11), 1 = p^b (6 rounds, index 6..11); sampled with start_i.
REQ-006 rnd_valid_i  input  1  fresh DOM randomness available; present only when ASCON_CTRL_RND_HANDSHAKE_EN is defined.
REQ-007 rcmode_o  output  2  round-constant generator mode: 00 clear, 01 increment wrap-to-0, 10 increment wrap-to-6, 11 load.
REQ-008 constti_o  output  4  round-constant load value, meaningful when rcmode_o = 11.
REQ-009 round_upd_o  output  1  one-cycle pulse; state-share registers capture the round result.
REQ-010 stage_o  output  2  current stage within a round, 0..ROUND_LAT-1.
REQ-011 rnd_req_o  output  1  randomness consumed this cycle.
REQ-012 busy_o  output  1  high from LOAD through DONE inclusive.
REQ-013 done_o  output  1  one-cycle pulse after final round update.

Function
REQ-014 FSM states IDLE, LOAD, ROUND, DONE shall be used, with no other states.
REQ-015 IDLE: rcmode_o = 00, busy_o = 0; start_i = 1 latches perm_sel_i and moves to LOAD next cycle.
REQ-016 LOAD (one cycle): rcmode_o = 11, constti_o = 0 (p^a) or 6 (p^b); shadow index rc_q loaded identically; round and stage counters cleared; next ROUND.
REQ-017 ROUND stage s < ROUND_LAT-1 with advance: stage increments; rcmode_o = 11, constti_o = rc_q (hold); round_upd_o = 0.
REQ-018 ROUND stage ROUND_LAT-1 with advance: round_upd_o = 1; rcmode_o = 01 (p^a) or 10 (p^b); rc_q follows the same increment/wrap rule; stage returns to 0; round counter increments.
REQ-019 Update of round 12 (p^a) or 6 (p^b) shall move to DONE; rc_q wrap (11->0 or 11->6) occurs on that same update.
REQ-020 DONE (one cycle): done_o = 1, rcmode_o = 00, busy_o = 1; next IDLE; start_i in DONE ignored.
REQ-021 start_i outside IDLE shall be ignored; perm_sel_i changes after LOAD have no effect.
REQ-022 Advance = 1 every ROUND cycle without the macro; rnd_req_o = 1 in every ROUND cycle with advance.
REQ-023 Total latency start_i to done_o: 2 + 12*ROUND_LAT cycles (p^a), 2 + 6*ROUND_LAT (p^b), absent stalls.

Reset
REQ-024 nRST low shall asynchronously force IDLE, counters and rc_q to 0, and every output to 0 (rcmode_o = 00), including mid-round; no done_o is issued for the aborted permutation.
REQ-025 First start_i after nRST release shall be honoured on the first rising edge.

Configuration
REQ-026 ASCON_CTRL_RND_HANDSHAKE_EN defined: rnd_valid_i exists; advance = rnd_valid_i in ROUND; when low, stage and round counters hold, rcmode_o = 11 with constti_o = rc_q, round_upd_o = 0, rnd_req_o = 0.
REQ-027 ASCON_CTRL_RND_HANDSHAKE_EN undefined: port absent, rounds never stall.

Structure
REQ-028 Shared package ascon_dom_pkg shall hold the FSM state enum, the rcmode encodings, PA_ROUNDS = 12, PB_ROUNDS = 6, PA_RC_START = 4'h0, PB_RC_START = 4'h6, RC_LAST = 4'hB.
REQ-029 No sub-module is required; the round-constant generator is instantiated beside this block by the parent, not inside it.

Verification
REQ-030 p^a, ROUND_LAT = 2, start_i pulse -> LOAD with constti_o = 0, 12 round_upd_o pulses on stage 1, done_o at cycle 26, rc_q sequence 0..B then 0.
REQ-031 p^b, ROUND_LAT = 1 -> constti_o = 6 in LOAD, six consecutive round_upd_o pulses with rcmode_o = 10, done_o at cycle 8.
REQ-032 start_i held high through an entire p^a run -> exactly one permutation per IDLE visit, busy_o continuous, perm_sel_i toggle mid-run ignored.
REQ-033 nRST asserted at round 5, stage 1 -> outputs 0 immediately (before next edge), no done_o; new p^b completes normally.
REQ-034 Macro defined, rnd_valid_i low for 3 cycles in round 2 -> stage frozen, rcmode_o = 11 with constti_o = 2, latency +3 cycles, still 12 updates.
